id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_if.sv | 42 ++++
 rtl/id_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Handshake and data bundle between fetch, register file, decode and execute.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface id_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       inst_i;
    logic [XLEN-1:0]   inst_addr_i;
    logic [REG_AW-1:0] rs1_addr_o;
    logic [REG_AW-1:0] rs2_addr_o;
    logic [XLEN-1:0]   rs1_data_i;
    logic [XLEN-1:0]   rs2_data_i;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       inst_o;
    logic [XLEN-1:0]   inst_addr_o;
    logic [XLEN-1:0]   op_num1_o;
    logic [XLEN-1:0]   op_num2_o;
    logic [XLEN-1:0]   imm_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              reg_wen_o;
    logic              illegal_o;

    modport slave (
        input  in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
        input  flush_i, out_ready_i,
        output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o,
        output inst_o, inst_addr_o, op_num1_o, op_num2_o, imm_o,
        output rd_addr_o, reg_wen_o, illegal_o
    );

    modport master (
        output in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
        output flush_i, out_ready_i,
        input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o,
        input  inst_o, inst_addr_o, op_num1_o, op_num2_o, imm_o,
        input  rd_addr_o, reg_wen_o, illegal_o
    );
endinterface

// File: rtl/id_stage.sv
// RV base-ISA instruction decode stage: combinational decode and register-file
// addressing, followed by a single registered output slot with valid/ready.
module id_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    id_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign inst   = bus.inst_i;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic            writes_rd;
    logic [XLEN-1:0] dec_op1;
    logic [XLEN-1:0] dec_op2;
    logic [XLEN-1:0] dec_imm;

    // Anything not recognised leaves every field at zero and is flagged illegal.
    always_comb begin
        legal     = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        dec_op1   = '0;
        dec_op2   = '0;
        dec_imm   = '0;
        case (opcode)
            OPC_OP_IMM: begin
                legal     = 1'b1;
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                dec_op1   = bus.rs1_data_i;
                dec_op2   = imm_i;
                dec_imm   = imm_i;
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    legal     = 1'b1;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    writes_rd = 1'b1;
                    dec_op1   = bus.rs1_data_i;
                    dec_op2   = bus.rs2_data_i;
                end
            end
            OPC_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    legal   = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    dec_op1 = bus.rs1_data_i;
                    dec_op2 = bus.rs2_data_i;
                    dec_imm = imm_b;
                end
            end
            OPC_JAL: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                dec_op1   = bus.inst_addr_i;
                dec_op2   = XLEN'(4);
                dec_imm   = imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    legal     = 1'b1;
                    use_rs1   = 1'b1;
                    writes_rd = 1'b1;
                    dec_op1   = bus.inst_addr_i;
                    dec_op2   = XLEN'(4);
                    dec_imm   = imm_i;
                end
            end
            OPC_LUI: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                dec_op1   = imm_u;
                dec_imm   = imm_u;
            end
            OPC_AUIPC: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                dec_op1   = bus.inst_addr_i;
                dec_op2   = imm_u;
                dec_imm   = imm_u;
            end
            OPC_LOAD: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    legal     = 1'b1;
                    use_rs1   = 1'b1;
                    writes_rd = 1'b1;
                    dec_op1   = bus.rs1_data_i;
                    dec_op2   = imm_i;
                    dec_imm   = imm_i;
                end
            end
            OPC_STORE: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
                    legal   = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    dec_op1 = bus.rs1_data_i;
                    dec_op2 = bus.rs2_data_i;
                    dec_imm = imm_s;
                end
            end
            default: ;
        endcase
    end

    logic [REG_AW-1:0] dec_rd;
    logic              dec_wen;

    assign bus.rs1_addr_o = use_rs1 ? REG_AW'(inst[19:15]) : '0;
    assign bus.rs2_addr_o = use_rs2 ? REG_AW'(inst[24:20]) : '0;
    assign dec_rd         = writes_rd ? REG_AW'(inst[11:7]) : '0;
    assign dec_wen        = writes_rd && (inst[11:7] != 5'd0);

    logic              out_valid_q, out_valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   inst_addr_q, inst_addr_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wen_q, wen_d;
    logic              ill_q, ill_d;
    logic              in_ready;
    logic              accept;

    assign in_ready = !out_valid_q || bus.out_ready_i;
    assign accept   = bus.in_valid_i && in_ready;

    // Flush wins over everything; data registers only move on an accept.
    always_comb begin
        out_valid_d = out_valid_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        wen_d       = wen_q;
        ill_d       = ill_q;
        if (bus.flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            inst_d      = inst;
            inst_addr_d = bus.inst_addr_i;
            op1_d       = dec_op1;
            op2_d       = dec_op2;
            imm_d       = dec_imm;
            rd_d        = dec_rd;
            wen_d       = dec_wen;
            ill_d       = !legal;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            inst_addr_q <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            wen_q       <= wen_d;
            ill_q       <= ill_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.inst_o      = inst_q;
    assign bus.inst_addr_o = inst_addr_q;
    assign bus.op_num1_o   = op1_q;
    assign bus.op_num2_o   = op2_q;
    assign bus.imm_o       = imm_q;
    assign bus.rd_addr_o   = rd_q;
    assign bus.reg_wen_o   = wen_q;
    assign bus.illegal_o   = ill_q;
endmodule

// File: tb/tb_id_stage.sv
// Table-driven bench for id_stage: a negedge scoreboard tracks the valid/ready
// handshake and compares each registered bundle while it is presented.
module tb_id_stage;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_fail = 0;

    id_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    id_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t tbl [19];
    vec_t cur;
    vec_t sb_q [$];
    logic model_valid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic valid, input logic rdy, input logic fl);
        cur             = v;
        bus.inst_i      = v.inst;
        bus.inst_addr_i = v.addr;
        bus.rs1_data_i  = v.rs1d;
        bus.rs2_data_i  = v.rs2d;
        bus.in_valid_i  = valid;
        bus.out_ready_i = rdy;
        bus.flush_i     = fl;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    // Reference handshake model plus output comparison, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        vec_t e;
        logic acc;
        if (!rst_n) begin
            model_valid = 1'b0;
            sb_q.delete();
        end else begin
            checkOutput("out_valid", 32'(bus.out_valid_o), 32'(model_valid));
            checkOutput("in_ready", 32'(bus.in_ready_o), 32'(!model_valid || bus.out_ready_i));
            if (bus.in_valid_i) begin
                checkOutput("rs1_addr", 32'(bus.rs1_addr_o), 32'(cur.rs1a));
                checkOutput("rs2_addr", 32'(bus.rs2_addr_o), 32'(cur.rs2a));
            end
            if (model_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL sb_underflow: got valid bundle expected none queued at %0t", $time);
                end else begin
                    e = sb_q[0];
                    if (!e.ill) begin
                        checkOutput("inst_o", bus.inst_o, e.inst);
                        checkOutput("inst_addr_o", bus.inst_addr_o, e.addr);
                    end
                    checkOutput("op_num1", bus.op_num1_o, e.op1);
                    checkOutput("op_num2", bus.op_num2_o, e.op2);
                    checkOutput("imm", bus.imm_o, e.imm);
                    checkOutput("rd_addr", 32'(bus.rd_addr_o), 32'(e.rd));
                    checkOutput("reg_wen", 32'(bus.reg_wen_o), 32'(e.wen));
                    checkOutput("illegal", 32'(bus.illegal_o), 32'(e.ill));
                end
            end
            acc = bus.in_valid_i && (!model_valid || bus.out_ready_i) && !bus.flush_i;
            if (model_valid && (bus.out_ready_i || bus.flush_i) && sb_q.size() > 0)
                void'(sb_q.pop_front());
            if (bus.flush_i) begin
                model_valid = 1'b0;
            end else if (acc) begin
                sb_q.push_back(cur);
                model_valid = 1'b1;
            end else if (bus.out_ready_i) begin
                model_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t idle;
        vec_t stall_v;
        // inst, addr, rs1d, rs2d, rs1a, rs2a, op1, op2, imm, rd, wen, ill
        tbl[0]  = '{32'h00500093, 32'h0,   32'h0,    32'h0,    5'd0,  5'd0,  32'h0,        32'h5,        32'h5,        5'd1, 1'b1, 1'b0};
        tbl[1]  = '{32'h00208463, 32'h4,   32'h7,    32'h7,    5'd1,  5'd2,  32'h7,        32'h7,        32'h8,        5'd0, 1'b0, 1'b0};
        tbl[2]  = '{32'h010000EF, 32'h100, 32'hDEAD, 32'hBEEF, 5'd0,  5'd0,  32'h100,      32'h4,        32'h10,       5'd1, 1'b1, 1'b0};
        tbl[3]  = '{32'h123452B7, 32'h104, 32'h1111, 32'h2222, 5'd0,  5'd0,  32'h12345000, 32'h0,        32'h12345000, 5'd5, 1'b1, 1'b0};
        tbl[4]  = '{32'h002081B3, 32'h108, 32'h11,   32'h22,   5'd1,  5'd2,  32'h11,       32'h22,       32'h0,        5'd3, 1'b1, 1'b0};
        tbl[5]  = '{32'h40628233, 32'h10C, 32'd100,  32'd30,   5'd5,  5'd6,  32'd100,      32'd30,       32'h0,        5'd4, 1'b1, 1'b0};
        tbl[6]  = '{32'h02208133, 32'h110, 32'h5,    32'h6,    5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b1};
        tbl[7]  = '{32'hFFF08013, 32'h114, 32'h5,    32'h9,    5'd1,  5'd0,  32'h5,        32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0};
        tbl[8]  = '{32'h80000397, 32'h200, 32'h3,    32'h4,    5'd0,  5'd0,  32'h200,      32'h80000000, 32'h80000000, 5'd7, 1'b1, 1'b0};
        tbl[9]  = '{32'h00C100E7, 32'h300, 32'h55,   32'h66,   5'd2,  5'd0,  32'h300,      32'h4,        32'hC,        5'd1, 1'b1, 1'b0};
        tbl[10] = '{32'hFFC4A403, 32'h304, 32'h1000, 32'h7,    5'd9,  5'd0,  32'h1000,     32'hFFFFFFFC, 32'hFFFFFFFC, 5'd8, 1'b1, 1'b0};
        tbl[11] = '{32'h00A5A423, 32'h308, 32'h2000, 32'hABCD, 5'd11, 5'd10, 32'h2000,     32'hABCD,     32'h8,        5'd0, 1'b0, 1'b0};
        tbl[12] = '{32'hFE209EE3, 32'h30C, 32'h1,    32'h2,    5'd1,  5'd2,  32'h1,        32'h2,        32'hFFFFFFFC, 5'd0, 1'b0, 1'b0};
        tbl[13] = '{32'h0020A463, 32'h310, 32'h1,    32'h2,    5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b1};
        tbl[14] = '{32'hFFFFFFFF, 32'h314, 32'h1,    32'h2,    5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b1};
        tbl[15] = '{32'h00C110E7, 32'h318, 32'h1,    32'h2,    5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b1};
        tbl[16] = '{32'h0004B403, 32'h31C, 32'h1,    32'h2,    5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b1};
        tbl[17] = '{32'hFF9FF06F, 32'h400, 32'h1,    32'h2,    5'd0,  5'd0,  32'h400,      32'h4,        32'hFFFFFFF8, 5'd0, 1'b0, 1'b0};
        tbl[18] = '{32'h7FF1E113, 32'h404, 32'h77,   32'h2,    5'd3,  5'd0,  32'h77,       32'h7FF,      32'h7FF,      5'd2, 1'b1, 1'b0};
        idle    = '{32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        #3;
        checkOutput("reset_out_valid", 32'(bus.out_valid_o), 32'h0);
        checkOutput("reset_in_ready", 32'(bus.in_ready_o), 32'h1);
        checkOutput("reset_op_num1", bus.op_num1_o, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        $display("[TB] decode table, full throughput");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i], 1'b1, 1'b1, 1'b0);
            stepCycle();
        end
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        stepCycle();
        stepCycle();

        $display("[TB] back-pressure with ADD held");
        applyStimulus(tbl[4], 1'b1, 1'b0, 1'b0);
        stepCycle();
        for (int k = 0; k < 3; k++) begin
            stall_v = '{32'h00338313, 32'h500, 32'hA0 + 32'(k), 32'hB0 + 32'(k), 5'd7, 5'd0,
                        32'hA0 + 32'(k), 32'h3, 32'h3, 5'd6, 1'b1, 1'b0};
            applyStimulus(stall_v, 1'b1, 1'b0, 1'b0);
            #1;
            checkOutput("bp_in_ready", 32'(bus.in_ready_o), 32'h0);
            checkOutput("bp_hold_op1", bus.op_num1_o, 32'h11);
            stepCycle();
        end
        stall_v = '{32'h00338313, 32'h500, 32'hD0, 32'hE0, 5'd7, 5'd0,
                    32'hD0, 32'h3, 32'h3, 5'd6, 1'b1, 1'b0};
        applyStimulus(stall_v, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("bp_release_ready", 32'(bus.in_ready_o), 32'h1);
        stepCycle();
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        stepCycle();
        stepCycle();

        $display("[TB] flush with held and incoming instructions");
        applyStimulus(tbl[5], 1'b1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(tbl[8], 1'b1, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(tbl[9], 1'b1, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(tbl[10], 1'b1, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(tbl[14], 1'b1, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        stepCycle();
        stepCycle();

        $display("[TB] asynchronous reset mid-handshake");
        applyStimulus(tbl[2], 1'b1, 1'b0, 1'b0);
        stepCycle();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(bus.out_valid_o), 32'h0);
        checkOutput("arst_in_ready", 32'(bus.in_ready_o), 32'h1);
        checkOutput("arst_inst", bus.inst_o, 32'h0);
        checkOutput("arst_inst_addr", bus.inst_addr_o, 32'h0);
        checkOutput("arst_op1", bus.op_num1_o, 32'h0);
        checkOutput("arst_op2", bus.op_num2_o, 32'h0);
        checkOutput("arst_imm", bus.imm_o, 32'h0);
        checkOutput("arst_rd", 32'(bus.rd_addr_o), 32'h0);
        checkOutput("arst_wen", 32'(bus.reg_wen_o), 32'h0);
        checkOutput("arst_illegal", 32'(bus.illegal_o), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(tbl[3], 1'b1, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        stepCycle();
        stepCycle();

        checkOutput("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
